// File: rtl/sram1rw_ctrl_pkg.sv
// Shared types, default geometry and helpers for the SRAM1RW initiator controller.
package sram1rw_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned DEF_ADDR_W    = 32'd7;
    localparam int unsigned DEF_DATA_W    = 32'd22;
    localparam int unsigned DEF_RSP_DEPTH = 32'd3;

    // Bits needed to index an n-entry structure; never less than one.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/sram1rw_ctrl_rsp_fifo.sv
// Response FIFO holding captured read data until the consumer takes it.
module sram1rw_ctrl_rsp_fifo
    import sram1rw_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_RSP_DEPTH,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned PW     = ptr_width(DEPTH),
    parameter int unsigned CW     = ptr_width(DEPTH + 32'd1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CW-1:0]     occ_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     occ_q, occ_d;
    logic              pop_s;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 32'd1)) ? '0 : (p + PW'(1));
    endfunction

    assign valid_o = (occ_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign occ_o   = occ_q;
    assign pop_s   = pop_i & valid_o;

    // Pointer and occupancy next-state; simultaneous push and pop keep occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_i) begin
            wr_ptr_d = ptr_next(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_i, pop_s})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Storage and pointer registers; entries clear so the head reads zero after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

    sram1rw_ctrl_rsp_fifo_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (push_i),
        .occ_i  (occ_q)
    );

endmodule

// File: rtl/sram1rw_ctrl_rsp_fifo_chk.sv
// Overflow check for the response FIFO; flow control must keep pushes away from a full FIFO.
module sram1rw_ctrl_rsp_fifo_chk #(
    parameter int unsigned DEPTH = 32'd3,
    parameter int unsigned CW    = 32'd2
) (
    input logic          clk_i,
    input logic          rst_ni,
    input logic          push_i,
    input logic [CW-1:0] occ_i
);

    // A capture landing on a full FIFO would silently drop read data.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        push_i |-> (occ_i != CW'(DEPTH)));

endmodule

// File: rtl/sram1rw_ctrl.sv
// Valid/ready front end for a single-port SRAM1RW macro with a buffered read-response stream.
// Define SRAM_CTRL_INIT_EN to zero-fill the macro with an address sweep after every reset.
module sram1rw_ctrl
    import sram1rw_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned RSP_DEPTH = DEF_RSP_DEPTH
) (
    input  logic              CE,
    input  logic              RSTB,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] sram_A,
    output logic [DATA_W-1:0] sram_I,
    output logic              sram_CSB,
    output logic              sram_WEB,
    output logic              sram_OEB,
    input  logic [DATA_W-1:0] sram_O,
    output logic              init_done
);

    localparam int unsigned CW = ptr_width(RSP_DEPTH + 32'd1);
    localparam int unsigned IW = CW + 32'd1;

    state_e            state_q, state_d;
    logic              init_done_q;
    logic              rd_pend_q, rd_pend_d;
    logic              fire_s;
    logic              sweep_last_s;
    logic [ADDR_W-1:0] init_addr_s;
    logic [CW-1:0]     occ_s;
    logic [IW-1:0]     inflight_s;

`ifdef SRAM_CTRL_INIT_EN
    localparam state_e RST_STATE = ST_INIT;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;

    // Sweep counter advances once per cycle while initialising.
    always_comb begin
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + ADDR_W'(1);
        end else begin
            init_cnt_d = init_cnt_q;
        end
    end

    // Sweep counter register.
    always_ff @(posedge CE or negedge RSTB) begin
        if (!RSTB) begin
            init_cnt_q <= '0;
        end else begin
            init_cnt_q <= init_cnt_d;
        end
    end

    assign init_addr_s  = init_cnt_q;
    assign sweep_last_s = (init_cnt_q == '1);
`else
    localparam state_e RST_STATE = ST_RUN;
    assign init_addr_s  = '0;
    assign sweep_last_s = 1'b0;
`endif

    // Reads fired or captured but not yet consumed bound acceptance, so rsp_ready never reaches req_ready.
    assign inflight_s = {1'b0, occ_s} + {{CW{1'b0}}, rd_pend_q};
    assign req_ready  = init_done_q & (inflight_s < IW'(RSP_DEPTH));
    assign fire_s     = req_valid & req_ready;
    assign init_done  = init_done_q;

    // Next state: leave INIT once the last address has been written.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                if (sweep_last_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = RST_STATE;
        endcase
    end

    // Macro pin drive and read-pending flag; strobes stay inactive unless a request fires.
    always_comb begin
        sram_CSB  = 1'b1;
        sram_WEB  = 1'b1;
        sram_OEB  = 1'b1;
        sram_A    = req_addr;
        sram_I    = req_wdata;
        rd_pend_d = 1'b0;
        case (state_q)
            ST_INIT: begin
                sram_CSB = 1'b0;
                sram_WEB = 1'b0;
                sram_A   = init_addr_s;
                sram_I   = '0;
            end
            ST_RUN: begin
                sram_CSB  = ~fire_s;
                sram_WEB  = ~(fire_s & req_we);
                sram_OEB  = ~(fire_s & ~req_we);
                rd_pend_d = fire_s & ~req_we;
            end
            default: begin
                sram_CSB = 1'b1;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge CE or negedge RSTB) begin
        if (!RSTB) begin
            state_q     <= RST_STATE;
            init_done_q <= 1'b0;
            rd_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_done_q <= (state_d == ST_RUN);
            rd_pend_q   <= rd_pend_d;
        end
    end

    sram1rw_ctrl_rsp_fifo #(.DEPTH(RSP_DEPTH), .DATA_W(DATA_W)) u_rsp_fifo (
        .clk_i       (CE),
        .rst_ni      (RSTB),
        .push_i      (rd_pend_q),
        .push_data_i (sram_O),
        .pop_i       (rsp_ready),
        .valid_o     (rsp_valid),
        .data_o      (rsp_rdata),
        .occ_o       (occ_s)
    );

endmodule

// File: doc/sram1rw_ctrl.md
Name: sram1rw_ctrl

Overview:
- Initiator-side controller for the single-port SRAM1RW macro family (default geometry 128x22).
- Converts a valid/ready request stream (read/write) into the macro's active-low CSB/WEB/OEB strobes.
- Tracks the macro's 1-cycle registered read latency and returns read data on a valid/ready response stream.
- A response FIFO absorbs consumer backpressure, because the macro's O holds only until the next read.

Parameters:
- ADDR_W, 7, address width; macro depth = 2**ADDR_W.
- DATA_W, 22, data width.
- RSP_DEPTH, 3, response FIFO entries; 3 is the minimum for full read throughput without a rsp_ready->req_ready combinational path.

Ports:
- CE  in  1  clock; same net as the macro's CE.
- RSTB  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  consumer ready.
- rsp_rdata  out  DATA_W  read data.
- sram_A  out  ADDR_W  to macro A.
- sram_I  out  DATA_W  to macro I.
- sram_CSB  out  1  to macro CSB.
- sram_WEB  out  1  to macro WEB.
- sram_OEB  out  1  to macro OEB.
- sram_O  in  DATA_W  from macro O.
- init_done  out  1  high once the block accepts requests.

Behaviour:
- Single clock CE. Reset is asynchronous and active-low on RSTB.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, FIFO empty, rd_pend=0, sram_CSB=1, sram_WEB=1, sram_OEB=1.
- fire = req_valid & req_ready.
- Macro pins are combinational from the request port and are sampled by the macro at posedge CE:
  - sram_CSB = ~fire
  - sram_WEB = ~(fire & req_we)
  - sram_OEB = ~(fire & ~req_we)
  - sram_A = req_addr
  - sram_I = req_wdata
- Strobes are never low while fire=0.
- rd_pend: register, set on a read fire, cleared otherwise.
- Capture: in a cycle with rd_pend=1, sram_O is pushed into the FIFO at the end of that cycle.
- Read latency: read fire in cycle N -> rsp_valid earliest in cycle N+2, in request order.
- Write: no response; committed at the fire edge.
- Single port: one operation per cycle.
  - A read fired the cycle after a write to the same address returns the new data.
  - A read and write can never co-issue.
- Flow control: req_ready = init_done & ((occ + rd_pend) < RSP_DEPTH). It is independent of req_we and rsp_ready, so there is no combinational path from rsp_ready.
- FIFO: rsp_valid = (occ != 0); rsp_rdata = head entry.
  - Push and pop in the same cycle leave occ unchanged.
  - Pop occurs when rsp_valid & rsp_ready.
  - Pointers wrap modulo RSP_DEPTH.
  - Overflow cannot occur by construction; a push while full is an assertion failure.
- With rsp_ready held 1, back-to-back reads sustain 1 read/cycle.
- Reset mid-operation: the in-flight read is discarded, the FIFO is cleared, and strobes go inactive immediately (asynchronous). Memory contents are unspecified.
- FSM states: INIT, RUN.
  - Without the optional feature, reset enters RUN directly and init_done=1 after reset release.

Optional Feature:
- SRAM_CTRL_INIT_EN.
- Defined: reset enters INIT.
  - A counter sweeps addresses 0 .. 2**ADDR_W-1, one per cycle, driving CSB=0, WEB=0, OEB=1, I=0.
  - In INIT: req_ready=0, init_done=0.
  - After the last address (counter wraps to 0) the FSM moves to RUN and init_done=1.
  - Default geometry: 128 cycles.
  - During INIT, the macro pins come from the counter, not the request port.
- Undefined: no INIT state, no counter; memory contents after reset are undefined.

Decomposition:
- Package sram1rw_ctrl_pkg:
  - state enum {INIT, RUN}
  - default ADDR_W/DATA_W/RSP_DEPTH constants
  - pointer-width helper function.
- Sub-module sram1rw_ctrl_rsp_fifo (RSP_DEPTH x DATA_W, occ output). The top holds the FSM, rd_pend and the pin drive.

Test Plan:
- Reset then write: write addr 0x05 data 0x2AAAAA, then read 0x05 -> rsp_rdata=0x2AAAAA in cycle N+2. The write produces no rsp_valid.
- Streaming reads with rsp_ready=1: write 0x00..0x7F with data = addr*3, then 128 back-to-back reads -> req_ready never drops; responses in order, 0x000..0x17D.
- Backpressure: rsp_ready=0, issue 5 reads -> exactly 3 accepted, req_ready=0 after the third, occ=3. Raising rsp_ready drains in order, with no loss or duplication.
- Read-after-write: write 0x10=0x11111 in cycle N, read 0x10 in N+1 -> 0x11111. Check strobes are never simultaneously low for read and write.
- Async reset with 2 responses queued and 1 read pending -> rsp_valid=0, CSB/WEB/OEB=1 without waiting for a CE edge. No stale response after release.
- SRAM_CTRL_INIT_EN defined: init_done rises exactly 128 cycles after reset release, and req_ready=0 until then. Reading 0x7F then returns 0.
